// File: rtl/cache_refill_mem_responder.sv
// Blocking 16B-line main-memory responder: one request in flight, fixed
// response latency, storage cleared by reset.
package cache_refill_mem_responder_pkg;
  typedef struct packed {
    logic [2:0]   type_;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16B_t;

  typedef struct packed {
    logic [2:0]   type_;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16B_t;
endpackage

module cache_refill_mem_responder
  import cache_refill_mem_responder_pkg::*;
#(
  parameter int p_nlines  = 256,
  parameter int p_latency = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  mem_req_16B_t  memreq_msg,
  input  logic          memreq_val,
  output logic          memreq_rdy,
  output mem_resp_16B_t memresp_msg,
  output logic          memresp_val,
  input  logic          memresp_rdy,
  output logic [1:0]    dbg_state
);
  localparam int idw = $clog2(p_nlines);

  // Handshakes: a transfer happens on a rising edge where both val and rdy
  // are high; val never depends on rdy, and the payload is held while val is
  // high and rdy is low.
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       type_q, type_d;
  logic [7:0]       opaque_q, opaque_d;
  logic [idw-1:0]   idx_q, idx_d;
  logic             rdy_q, rdy_d;
  logic             val_q, val_d;
  logic             wr_en;
  logic [idw-1:0]   req_idx;
  logic [127:0]     mem_q [p_nlines];

  assign req_idx = memreq_msg.addr[4 +: idw];

  logic unused_req_bits;
  assign unused_req_bits = ^{memreq_msg.len, memreq_msg.addr[3:0],
                             memreq_msg.addr[31:4+idw]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    type_d   = type_q;
    opaque_d = opaque_q;
    idx_d    = idx_q;
    rdy_d    = rdy_q;
    val_d    = val_q;
    wr_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (memreq_val) begin
          type_d   = memreq_msg.type_;
          opaque_d = memreq_msg.opaque;
          idx_d    = req_idx;
          wr_en    = (memreq_msg.type_ == 3'd1) || (memreq_msg.type_ == 3'd2);
          cnt_d    = 4'(p_latency);
          rdy_d    = 1'b0;
          if (p_latency == 0) begin
            state_d = ST_RESP;
            val_d   = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // The cycle holding count 1 is the last idle cycle before the response.
        if (cnt_q <= 4'd1) begin
          state_d = ST_RESP;
          val_d   = 1'b1;
        end
      end
      ST_RESP: begin
        if (memresp_rdy) begin
          state_d = ST_IDLE;
          val_d   = 1'b0;
          rdy_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        val_d   = 1'b0;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      type_q   <= '0;
      opaque_q <= '0;
      idx_q    <= '0;
      rdy_q    <= 1'b1;
      val_q    <= 1'b0;
      for (int i = 0; i < p_nlines; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      type_q   <= type_d;
      opaque_q <= opaque_d;
      idx_q    <= idx_d;
      rdy_q    <= rdy_d;
      val_q    <= val_d;
      if (wr_en) mem_q[req_idx] <= memreq_msg.data;
    end
  end

  // Gating with reset keeps both handshake outputs low in every reset cycle,
  // including the first one before the synchronous reset has taken effect.
  assign memreq_rdy  = rdy_q & reset;
  assign memresp_val = val_q & reset;
  assign dbg_state   = state_q;

  always_comb begin
    memresp_msg        = '0;
    memresp_msg.type_  = type_q;
    memresp_msg.opaque = opaque_q;
    memresp_msg.data   = (type_q == 3'd0) ? mem_q[idx_q] : 128'd0;
  end
endmodule

// File: tb/tb_cache_refill_mem_responder.sv
// Directed bench for cache_refill_mem_responder: latency-2 and latency-0
// instances driven through reset, round trips, aliasing, back-pressure.
module tb_cache_refill_mem_responder;
  import cache_refill_mem_responder_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  mem_req_16B_t  req_msg, req0_msg;
  logic          req_val, req_rdy, req0_val, req0_rdy;
  mem_resp_16B_t resp_msg, resp0_msg, exp_r;
  logic          resp_val, resp_rdy, resp0_val, resp0_rdy;
  logic [1:0]    st, st0;
  int            checks = 0;
  int            failures = 0;

  localparam logic [127:0] D1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] DA = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
  localparam logic [127:0] DB = 128'hBBBB_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [127:0] DI = 128'h1D1D_1D1D_0000_FFFF_1234_5678_9ABC_DEF0;
  localparam logic [127:0] DX = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [127:0] DC = 128'hC0C0_C0C0_C0C0_C0C0_C0C0_C0C0_C0C0_C0C0;
  localparam logic [127:0] DZ = 128'h5A5A_0000_1111_2222_3333_4444_5555_A5A5;

  cache_refill_mem_responder #(.p_nlines(256), .p_latency(2)) dut (
    .clk(clk), .reset(reset),
    .memreq_msg(req_msg), .memreq_val(req_val), .memreq_rdy(req_rdy),
    .memresp_msg(resp_msg), .memresp_val(resp_val), .memresp_rdy(resp_rdy),
    .dbg_state(st)
  );

  cache_refill_mem_responder #(.p_nlines(256), .p_latency(0)) dut0 (
    .clk(clk), .reset(reset),
    .memreq_msg(req0_msg), .memreq_val(req0_val), .memreq_rdy(req0_rdy),
    .memresp_msg(resp0_msg), .memresp_val(resp0_val), .memresp_rdy(resp0_rdy),
    .dbg_state(st0)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic mem_resp_16B_t mk_resp(input logic [2:0] t, input logic [7:0] op,
                                            input logic [127:0] d);
    mem_resp_16B_t r;
    r = '0;
    r.type_ = t;
    r.opaque = op;
    r.data = d;
    return r;
  endfunction

  // Issue one request on the latency-2 instance, return its response and the
  // number of cycles from the accept cycle to the first valid response cycle.
  task automatic do_req(input logic [2:0] t, input logic [7:0] op, input logic [31:0] addr,
                        input logic [127:0] d, output mem_resp_16B_t r, output int lat);
    int guard = 0;
    req_msg = '0;
    req_msg.type_ = t;
    req_msg.opaque = op;
    req_msg.addr = addr;
    req_msg.len = 4'hF;
    req_msg.data = d;
    req_val = 1'b1;
    while (!req_rdy && guard < 20) begin @(negedge clk); guard++; end
    chk("req_accept", {191'd0, req_rdy}, 192'd1);
    @(negedge clk);
    req_val = 1'b0;
    lat = 1;
    while (!resp_val && lat < 40) begin @(negedge clk); lat++; end
    r = resp_msg;
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
    chk("post_hs_val", {191'd0, resp_val}, 192'd0);
    chk("post_hs_rdy", {191'd0, req_rdy}, 192'd1);
  endtask

  initial begin
    mem_resp_16B_t r;
    int lat;
    reset = 1'b0;
    req_val = 1'b0; req0_val = 1'b0;
    resp_rdy = 1'b0; resp0_rdy = 1'b0;
    req_msg = '0; req0_msg = '0;

    // Reset then idle
    repeat (2) begin
      @(negedge clk);
      chk("rst_req_rdy", {191'd0, req_rdy}, 192'd0);
      chk("rst_resp_val", {191'd0, resp_val}, 192'd0);
      chk("rst0_req_rdy", {191'd0, req0_rdy}, 192'd0);
    end
    reset = 1'b1;
    #1;
    chk("rel_req_rdy", {191'd0, req_rdy}, 192'd1);
    chk("rel_resp_msg", {47'd0, resp_msg}, 192'd0);
    chk("rel_state", {190'd0, st}, 192'd0);
    @(negedge clk);
    do_req(3'd0, 8'h00, 32'h0000_0040, 128'd0, r, lat);
    chk("rd0_lat", lat, 3);
    chk("rd0_resp", {47'd0, r}, {47'd0, mk_resp(3'd0, 8'h00, 128'd0)});

    // Write/read round trip
    do_req(3'd1, 8'h5A, 32'h0000_1230, D1, r, lat);
    chk("wr_lat", lat, 3);
    chk("wr_resp", {47'd0, r}, {47'd0, mk_resp(3'd1, 8'h5A, 128'd0)});
    do_req(3'd0, 8'h5B, 32'h0000_1234, 128'd0, r, lat);
    chk("rd_resp", {47'd0, r}, {47'd0, mk_resp(3'd0, 8'h5B, D1)});

    // Aliasing: 0x1010 and 0x0010 both map to line 1
    do_req(3'd1, 8'h01, 32'h0000_0010, DA, r, lat);
    do_req(3'd0, 8'h02, 32'h0000_1010, 128'd0, r, lat);
    chk("alias_resp", {47'd0, r}, {47'd0, mk_resp(3'd0, 8'h02, DA)});

    // INIT writes; an unknown type leaves the line untouched
    do_req(3'd2, 8'h11, 32'h0000_0300, DI, r, lat);
    chk("init_resp", {47'd0, r}, {47'd0, mk_resp(3'd2, 8'h11, 128'd0)});
    do_req(3'd5, 8'h12, 32'h0000_0300, DX, r, lat);
    chk("other_resp", {47'd0, r}, {47'd0, mk_resp(3'd5, 8'h12, 128'd0)});
    do_req(3'd0, 8'h13, 32'h0000_030C, 128'd0, r, lat);
    chk("init_rd_resp", {47'd0, r}, {47'd0, mk_resp(3'd0, 8'h13, DI)});

    // Back-pressure with memreq_val held high
    do_req(3'd1, 8'h76, 32'h0000_0020, DB, r, lat);
    req_msg = '0;
    req_msg.type_ = 3'd0;
    req_msg.opaque = 8'h77;
    req_msg.addr = 32'h0000_0020;
    req_val = 1'b1;
    chk("bp_accept_rdy", {191'd0, req_rdy}, 192'd1);
    @(negedge clk);
    lat = 1;
    while (!resp_val && lat < 40) begin @(negedge clk); lat++; end
    chk("bp_lat", lat, 3);
    exp_r = mk_resp(3'd0, 8'h77, DB);
    for (int i = 0; i < 5; i++) begin
      chk("bp_val", {191'd0, resp_val}, 192'd1);
      chk("bp_msg", {47'd0, resp_msg}, {47'd0, exp_r});
      chk("bp_req_rdy", {191'd0, req_rdy}, 192'd0);
      chk("bp_state", {190'd0, st}, 192'd2);
      @(negedge clk);
    end
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
    req_val = 1'b0;
    chk("bp_post_val", {191'd0, resp_val}, 192'd0);
    chk("bp_post_rdy", {191'd0, req_rdy}, 192'd1);
    repeat (4) begin
      @(negedge clk);
      chk("bp_single_resp", {191'd0, resp_val}, 192'd0);
    end

    // Zero-latency instance: write then back-to-back reads, rdy held high
    resp0_rdy = 1'b1;
    req0_val = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("z_req_rdy", {191'd0, req0_rdy}, {191'd0, (i % 2 == 0)});
      chk("z_resp_val", {191'd0, resp0_val}, {191'd0, (i % 2 == 1)});
      if (i % 2 == 0) begin
        req0_msg = '0;
        req0_msg.type_ = (i == 0) ? 3'd1 : 3'd0;
        req0_msg.opaque = 8'(8'h80 + i);
        req0_msg.addr = 32'h0000_0070;
        req0_msg.data = (i == 0) ? DZ : 128'd0;
      end else begin
        chk("z_resp_msg", {47'd0, resp0_msg},
            {47'd0, mk_resp((i == 1) ? 3'd1 : 3'd0, 8'(8'h80 + i - 1),
                            (i == 1) ? 128'd0 : DZ)});
      end
      @(negedge clk);
    end
    req0_val = 1'b0;
    resp0_rdy = 1'b0;
    chk("z_idle_rdy", {191'd0, req0_rdy}, 192'd1);

    // Reset during WAIT after a WRITE
    req_msg = '0;
    req_msg.type_ = 3'd1;
    req_msg.opaque = 8'h33;
    req_msg.addr = 32'h0000_0050;
    req_msg.data = DC;
    req_val = 1'b1;
    chk("mf_accept_rdy", {191'd0, req_rdy}, 192'd1);
    @(negedge clk);
    req_val = 1'b0;
    chk("mf_in_wait", {190'd0, st}, 192'd1);
    reset = 1'b0;
    #1;
    chk("mf_rst_rdy", {191'd0, req_rdy}, 192'd0);
    chk("mf_rst_val", {191'd0, resp_val}, 192'd0);
    @(negedge clk);
    chk("mf_rst_val2", {191'd0, resp_val}, 192'd0);
    @(negedge clk);
    reset = 1'b1;
    resp_rdy = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("mf_no_resp", {191'd0, resp_val}, 192'd0);
    end
    do_req(3'd0, 8'h34, 32'h0000_0050, 128'd0, r, lat);
    chk("mf_rd_resp", {47'd0, r}, {47'd0, mk_resp(3'd0, 8'h34, 128'd0)});
    do_req(3'd0, 8'h35, 32'h0000_1230, 128'd0, r, lat);
    chk("mf_cleared", {47'd0, r}, {47'd0, mk_resp(3'd0, 8'h35, 128'd0)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
